// File: rtl/uart_tx_frame.sv
// UART frame serializer: start bit, DATA_WIDTH data bits LSB-first, optional
// even/odd parity bit, stop bit. One clk cycle is one bit period.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_tx;
  logic                  r_busy;

  // Handshake: data_valid is sampled only in IDLE; anything presented while
  // busy=1 (STOP cycle included) is dropped, so upstream must hold or
  // re-present the word until it sees busy=0. Frames are thus separated by
  // at least one idle-high cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (data_valid) begin
            // Parity is fixed at latch time so live inputs cannot alter it.
            r_shift   <= p_data;
            r_par_en  <= par_en;
            r_par_bit <= (^p_data) ^ par_typ;
            r_state   <= S_START;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
          end else begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        S_START: begin
          r_tx    <= r_shift[0];
          r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
          r_cnt   <= '0;
          r_state <= S_DATA;
        end
        S_DATA: begin
          if (r_cnt == LAST_BIT) begin
            r_cnt <= '0;
            if (r_par_en) begin
              r_tx    <= r_par_bit;
              r_state <= S_PARITY;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
          end
        end
        S_PARITY: begin
          r_tx    <= 1'b1;
          r_state <= S_STOP;
        end
        S_STOP: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_out = r_tx;
  assign busy   = r_busy;

endmodule
